// File: rtl/ttt_board_ctrl_pkg.sv
// Shared definitions for the Tic-Tac-Toe board controller: cell codes,
// FSM states and the table of winning lines.
package ttt_board_ctrl_pkg;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_O     = 2'b01;
  localparam logic [1:0] CELL_X     = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOCATE = 3'd1,
    ST_CHECK  = 3'd2,
    ST_WRITE  = 3'd3,
    ST_EVAL   = 3'd4,
    ST_OVER   = 3'd5
  } state_t;

  // Cell index triples: rows, columns, diagonals
  localparam int WIN_LINES [8][3] = '{
    '{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8},
    '{0, 3, 6}, '{1, 4, 7}, '{2, 5, 8},
    '{0, 4, 8}, '{2, 4, 6}
  };

  function automatic logic [1:0] cell_at(input logic [17:0] b, input int idx);
    return b[2*idx +: 2];
  endfunction

endpackage

// File: rtl/ttt_win_detect.sv
// Combinational line/full detector for a packed 3x3 board.
module ttt_win_detect
  import ttt_board_ctrl_pkg::*;
(
  input  logic [17:0] board,
  output logic [1:0]  winner,
  output logic        full
);

  // Scan the eight lines; first completed line names the winner
  always_comb begin
    winner = CELL_EMPTY;
    full   = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (cell_at(board, i) == CELL_EMPTY) full = 1'b0;
    end
    for (int l = 0; l < 8; l++) begin
      if (winner == CELL_EMPTY &&
          cell_at(board, WIN_LINES[l][0]) != CELL_EMPTY &&
          cell_at(board, WIN_LINES[l][0]) == cell_at(board, WIN_LINES[l][1]) &&
          cell_at(board, WIN_LINES[l][0]) == cell_at(board, WIN_LINES[l][2]))
        winner = cell_at(board, WIN_LINES[l][0]);
    end
  end

endmodule

// File: rtl/ttt_board_ctrl.sv
// Turns a mouse click over the board into a Tic-Tac-Toe move, owns the
// board register, rejects illegal moves and reports the game outcome.
//
//   state  | meaning
//   IDLE   | waiting for a fresh button press
//   LOCATE | map captured cursor to a cell, drop off-board clicks
//   CHECK  | drop clicks on an occupied cell
//   WRITE  | write the mover's mark into the board
//   EVAL   | register outcome and ack for the mover
//   OVER   | game finished, only reset leaves
module ttt_board_ctrl
  import ttt_board_ctrl_pkg::*;
#(
  parameter int ORIGIN_X = 80,
  parameter int ORIGIN_Y = 0,
  parameter int CELL_W   = 160,
  parameter int CELL_H   = 160
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mouse_btn,
  input  logic [9:0]  cursor_x,
  input  logic [9:0]  cursor_y,
  input  logic        turn_x,
  output logic [17:0] board,
  output logic        o_status_ack,
  output logic        x_status_ack,
  output logic        win_signal,
  output logic [1:0]  winner,
  output logic        draw,
  output logic        busy
);

  localparam logic [10:0] X_ORG = 11'(ORIGIN_X);
  localparam logic [10:0] Y_ORG = 11'(ORIGIN_Y);
  localparam logic [10:0] X_B1  = 11'(CELL_W);
  localparam logic [10:0] X_B2  = 11'(2 * CELL_W);
  localparam logic [10:0] X_B3  = 11'(3 * CELL_W);
  localparam logic [10:0] Y_B1  = 11'(CELL_H);
  localparam logic [10:0] Y_B2  = 11'(2 * CELL_H);
  localparam logic [10:0] Y_B3  = 11'(3 * CELL_H);

  state_t      state, state_nx;
  logic        btn_q, press;
  logic [9:0]  cx_q, cy_q;
  logic        mover_x_q;
  logic [3:0]  cell_q;
  logic [11:0] dx, dy;
  logic [1:0]  col, row;
  logic        in_board;
  logic [3:0]  cell_idx;
  logic        cell_taken;
  logic [1:0]  wd_winner;
  logic        wd_full;

  assign press      = mouse_btn & ~btn_q;
  // Bit 11 of the offset flags a cursor left of / above the board
  assign dx         = {2'b00, cx_q} - {1'b0, X_ORG};
  assign dy         = {2'b00, cy_q} - {1'b0, Y_ORG};
  assign cell_taken = board[{cell_q, 1'b0} +: 2] != CELL_EMPTY;
  assign win_signal = |winner;
  assign busy       = (state != ST_IDLE) && (state != ST_OVER);

  ttt_win_detect u_win_detect (
    .board  (board),
    .winner (wd_winner),
    .full   (wd_full)
  );

  // Cell mapper: threshold compares on the cursor offset, no divider
  always_comb begin
    col      = (dx[10:0] < X_B1) ? 2'd0 : (dx[10:0] < X_B2) ? 2'd1 : 2'd2;
    row      = (dy[10:0] < Y_B1) ? 2'd0 : (dy[10:0] < Y_B2) ? 2'd1 : 2'd2;
    in_board = ~dx[11] & (dx[10:0] < X_B3) & ~dy[11] & (dy[10:0] < Y_B3);
    cell_idx = {1'b0, row, 1'b0} + {2'b00, row} + {2'b00, col};
  end

  // FSM state register
  always_ff @(posedge clock) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // FSM next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (press) state_nx = ST_LOCATE;
      ST_LOCATE: state_nx = in_board ? ST_CHECK : ST_IDLE;
      ST_CHECK:  state_nx = cell_taken ? ST_IDLE : ST_WRITE;
      ST_WRITE:  state_nx = ST_EVAL;
      ST_EVAL:   state_nx = (wd_winner != CELL_EMPTY || wd_full) ? ST_OVER : ST_IDLE;
      ST_OVER:   state_nx = ST_OVER;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // Datapath: press capture, cell latch, board write and outcome registers
  always_ff @(posedge clock) begin
    if (!reset) begin
      btn_q        <= 1'b0;
      cx_q         <= '0;
      cy_q         <= '0;
      mover_x_q    <= 1'b0;
      cell_q       <= '0;
      board        <= '0;
      o_status_ack <= 1'b0;
      x_status_ack <= 1'b0;
      winner       <= CELL_EMPTY;
      draw         <= 1'b0;
    end else begin
      btn_q <= mouse_btn;
      case (state)
        ST_IDLE: begin
          if (press) begin
            cx_q         <= cursor_x;
            cy_q         <= cursor_y;
            mover_x_q    <= turn_x;
            o_status_ack <= 1'b0;
            x_status_ack <= 1'b0;
          end
        end
        ST_LOCATE: cell_q <= cell_idx;
        ST_WRITE:  board[{cell_q, 1'b0} +: 2] <= mover_x_q ? CELL_X : CELL_O;
        ST_EVAL: begin
          winner       <= wd_winner;
          draw         <= wd_full & (wd_winner == CELL_EMPTY);
          x_status_ack <= mover_x_q;
          o_status_ack <= ~mover_x_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ttt_board_ctrl.sv
// Bench for ttt_board_ctrl: constant vector table, hand-written corner
// sequences and random games checked against a board-level game model.
module tb_ttt_board_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        mouse_btn = 1'b0;
  logic [9:0]  cursor_x = '0;
  logic [9:0]  cursor_y = '0;
  logic        turn_x = 1'b0;
  logic [17:0] board;
  logic        o_status_ack, x_status_ack, win_signal, draw, busy;
  logic [1:0]  winner;

  always #5 clock = ~clock;

  ttt_board_ctrl dut (
    .clock        (clock),
    .reset        (reset),
    .mouse_btn    (mouse_btn),
    .cursor_x     (cursor_x),
    .cursor_y     (cursor_y),
    .turn_x       (turn_x),
    .board        (board),
    .o_status_ack (o_status_ack),
    .x_status_ack (x_status_ack),
    .win_signal   (win_signal),
    .winner       (winner),
    .draw         (draw),
    .busy         (busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- game model ----------------
  int   m_cell [9];      // 0 empty, 1 O, 2 X
  bit   m_over, m_o, m_x, m_draw;
  int   m_winner;
  int   lines [8][3] = '{'{0,1,2},'{3,4,5},'{6,7,8},'{0,3,6},
                         '{1,4,7},'{2,5,8},'{0,4,8},'{2,4,6}};

  function automatic void m_reset();
    foreach (m_cell[i]) m_cell[i] = 0;
    m_over = 0; m_o = 0; m_x = 0; m_draw = 0; m_winner = 0;
  endfunction

  function automatic void m_press(input int x, input int y, input bit t);
    int idx, nfull;
    if (m_over) return;
    m_o = 0; m_x = 0;
    if (x < 80 || x >= 80 + 3*160 || y < 0 || y >= 3*160) return;
    idx = ((y - 0) / 160) * 3 + (x - 80) / 160;
    if (m_cell[idx] != 0) return;
    m_cell[idx] = t ? 2 : 1;
    if (t) m_x = 1; else m_o = 1;
    for (int l = 0; l < 8; l++)
      if (m_winner == 0 && m_cell[lines[l][0]] != 0 &&
          m_cell[lines[l][0]] == m_cell[lines[l][1]] &&
          m_cell[lines[l][0]] == m_cell[lines[l][2]])
        m_winner = m_cell[lines[l][0]];
    nfull = 0;
    foreach (m_cell[i]) if (m_cell[i] != 0) nfull++;
    m_draw = (nfull == 9) && (m_winner == 0);
    if (m_winner != 0 || nfull == 9) m_over = 1;
  endfunction

  function automatic logic [17:0] m_board();
    logic [17:0] b;
    b = '0;
    foreach (m_cell[i]) b[2*i +: 2] = 2'(m_cell[i]);
    return b;
  endfunction

  function automatic int cell_x(input int idx); return 80 + (idx % 3) * 160 + 80; endfunction
  function automatic int cell_y(input int idx); return (idx / 3) * 160 + 80; endfunction

  // ---------------- stimulus helpers ----------------
  logic [17:0] board_mid;

  // Button rises before edge 1; board sampled after edge 4, outcome after edge 5
  task automatic press_raw(input int x, input int y, input bit t);
    @(negedge clock);
    cursor_x = 10'(x); cursor_y = 10'(y); turn_x = t; mouse_btn = 1'b1;
    repeat (4) @(posedge clock);
    #1 board_mid = board;
    @(posedge clock);
    #1;
  endtask

  task automatic release_btn();
    @(negedge clock);
    mouse_btn = 1'b0;
    @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0; mouse_btn = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    m_reset();
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".board4"}, 32'(board_mid), 32'(m_board()));
    chk({tag, ".board"},  32'(board), 32'(m_board()));
    chk({tag, ".o_ack"},  32'(o_status_ack), 32'(m_o));
    chk({tag, ".x_ack"},  32'(x_status_ack), 32'(m_x));
    chk({tag, ".winner"}, 32'(winner), 32'(m_winner));
    chk({tag, ".win"},    32'(win_signal), 32'(m_winner != 0));
    chk({tag, ".draw"},   32'(draw), 32'(m_draw));
    chk({tag, ".busy"},   32'(busy), 32'(0));
  endtask

  task automatic mpress(input int x, input int y, input bit t, input string tag);
    m_press(x, y, t);
    press_raw(x, y, t);
    check_model(tag);
    release_btn();
  endtask

  task automatic mcell(input int idx, input bit t, input string tag);
    mpress(cell_x(idx), cell_y(idx), t, tag);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int          x;
    int          y;
    bit          t;
    logic [17:0] exp_board;
    bit          exp_o;
    bit          exp_x;
    logic [1:0]  exp_winner;
  } vec_t;

  vec_t vecs [11];

  initial begin
    vecs[0]  = '{100, 20,  1'b0, 18'h00001, 1'b1, 1'b0, 2'b00}; // O -> cell 0
    vecs[1]  = '{100, 20,  1'b1, 18'h00001, 1'b0, 1'b0, 2'b00}; // occupied
    vecs[2]  = '{50,  200, 1'b1, 18'h00001, 1'b0, 1'b0, 2'b00}; // left of board
    vecs[3]  = '{79,  20,  1'b1, 18'h00001, 1'b0, 1'b0, 2'b00}; // one px left
    vecs[4]  = '{560, 20,  1'b1, 18'h00001, 1'b0, 1'b0, 2'b00}; // one px right
    vecs[5]  = '{300, 480, 1'b1, 18'h00001, 1'b0, 1'b0, 2'b00}; // one px below
    vecs[6]  = '{559, 479, 1'b1, 18'h20001, 1'b0, 1'b1, 2'b00}; // X -> cell 8
    vecs[7]  = '{260, 20,  1'b0, 18'h20005, 1'b1, 1'b0, 2'b00}; // O -> cell 1
    vecs[8]  = '{240, 160, 1'b1, 18'h20205, 1'b0, 1'b1, 2'b00}; // X -> cell 4 corner
    vecs[9]  = '{420, 20,  1'b0, 18'h20215, 1'b1, 1'b0, 2'b01}; // O -> cell 2, wins
    vecs[10] = '{420, 200, 1'b1, 18'h20215, 1'b1, 1'b0, 2'b01}; // ignored in OVER

    // reset state
    repeat (2) @(posedge clock);
    #1;
    chk("rst.board", 32'(board), 0);
    chk("rst.acks",  32'({o_status_ack, x_status_ack}), 0);
    chk("rst.win",   32'({win_signal, winner, draw}), 0);
    chk("rst.busy",  32'(busy), 0);
    do_reset();

    foreach (vecs[i]) begin
      press_raw(vecs[i].x, vecs[i].y, vecs[i].t);
      chk($sformatf("vec%0d.board4", i), 32'(board_mid), 32'(vecs[i].exp_board));
      chk($sformatf("vec%0d.o_ack", i),  32'(o_status_ack), 32'(vecs[i].exp_o));
      chk($sformatf("vec%0d.x_ack", i),  32'(x_status_ack), 32'(vecs[i].exp_x));
      chk($sformatf("vec%0d.winner", i), 32'(winner), 32'(vecs[i].exp_winner));
      chk($sformatf("vec%0d.win", i),    32'(win_signal), 32'(vecs[i].exp_winner != 2'b00));
      chk($sformatf("vec%0d.draw", i),   32'(draw), 0);
      chk($sformatf("vec%0d.busy", i),   32'(busy), 0);
      release_btn();
    end

    // full board, no line
    do_reset();
    mcell(0, 0, "dr0"); mcell(1, 1, "dr1"); mcell(2, 0, "dr2");
    mcell(4, 1, "dr3"); mcell(3, 0, "dr4"); mcell(5, 1, "dr5");
    mcell(7, 0, "dr6"); mcell(6, 1, "dr7"); mcell(8, 0, "dr8");
    chk("draw.flag", 32'(draw), 1);
    chk("draw.win",  32'(win_signal), 0);

    // line completed by the 9th move
    do_reset();
    mcell(1, 0, "w90"); mcell(0, 1, "w91"); mcell(4, 0, "w92");
    mcell(2, 1, "w93"); mcell(5, 0, "w94"); mcell(3, 1, "w95");
    mcell(6, 0, "w96"); mcell(8, 1, "w97"); mcell(7, 0, "w98");
    chk("win9.draw",   32'(draw), 0);
    chk("win9.win",    32'(win_signal), 1);
    chk("win9.winner", 32'(winner), 32'h1);

    // held button gives exactly one move
    do_reset();
    @(negedge clock);
    cursor_x = 10'(cell_x(4)); cursor_y = 10'(cell_y(4)); turn_x = 1'b1; mouse_btn = 1'b1;
    repeat (100) @(posedge clock);
    #1;
    chk("hold.board", 32'(board), 32'h00200);
    chk("hold.x_ack", 32'(x_status_ack), 1);
    chk("hold.busy",  32'(busy), 0);
    m_press(cell_x(4), cell_y(4), 1'b1);
    release_btn();
    mcell(0, 0, "hold.next");

    // reset while in WRITE
    do_reset();
    @(negedge clock);
    cursor_x = 10'(cell_x(0)); cursor_y = 10'(cell_y(0)); turn_x = 1'b0; mouse_btn = 1'b1;
    repeat (3) @(posedge clock);
    #1 chk("wr.busy", 32'(busy), 1);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    chk("wr.board", 32'(board), 0);
    chk("wr.acks",  32'({o_status_ack, x_status_ack}), 0);
    chk("wr.flags", 32'({win_signal, winner, draw}), 0);
    chk("wr.busyr", 32'(busy), 0);
    @(negedge clock);
    reset = 1'b1; mouse_btn = 1'b0;
    m_reset();
    @(negedge clock);
    mcell(0, 0, "wr.next");

    // random games against the model
    for (int g = 0; g < 30; g++) begin
      do_reset();
      for (int k = 0; k < 20; k++)
        mpress(int'($urandom_range(0, 700)), int'($urandom_range(0, 540)),
               1'($urandom), $sformatf("rnd%0d_%0d", g, k));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
